bit_map_pipe: RTL and testbench

BIT_MAP_PIPE -- requirements
Module: bit_map_pipe

---
 rtl/bit_map_pipe.sv | 110 +++++++++++
 tb/tb_bit_map_pipe.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bit_map_pipe.sv
// bit_map_pipe: per-lane bit permutation feeding a 2-entry skid buffer.
// Words are mapped on acceptance with the mode active in that cycle, then
// held in head/tail registers; m_data is the head register.

// Single-lane bit permutation, purely combinational.
module bit_map_lane (
    input  logic [1:0] mode,
    input  logic [7:0] din,
    output logic [7:0] dout
);
    // Select one of four fixed bit permutations of the byte.
    always_comb begin
        dout = din;
        case (mode)
            2'b01: dout = {din[0], din[2], din[4], din[6],
                           din[1], din[3], din[5], din[7]};
            2'b10: dout = {din[0], din[4], din[1], din[5],
                           din[2], din[6], din[3], din[7]};
            2'b11: for (int k = 0; k < 8; k++) dout[k] = din[7-k];
            default: dout = din;
        endcase
    end
endmodule

module bit_map_pipe #(
    parameter int LANES = 8,
    parameter int CNT_W = 16,
    localparam int DW   = 8*LANES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode_in,
    input  logic             mode_load,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DW-1:0]    s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DW-1:0]    m_data,
    output logic [1:0]       mode_active,
    output logic [CNT_W-1:0] xfer_cnt
);
    logic [DW-1:0] mapped;
    logic [DW-1:0] head, tail;
    logic [1:0]    occ, occ_nxt;
    logic          push, pop;

    // Lanes are independent: lane i of the output sees only lane i of s_data.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        bit_map_lane u_lane (
            .mode (mode_active),
            .din  (s_data[8*i +: 8]),
            .dout (mapped[8*i +: 8])
        );
    end

    assign push    = s_valid & s_ready;
    assign pop     = m_valid & m_ready;
    assign m_valid = (occ != 2'd0);
    assign m_data  = head;

    // Next occupancy from the push/pop pair.
    always_comb begin
        occ_nxt = occ;
        case ({push, pop})
            2'b10:   occ_nxt = occ + 2'd1;
            2'b01:   occ_nxt = occ - 2'd1;
            default: occ_nxt = occ;
        endcase
    end

    // Occupancy and a registered ready derived only from next occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ     <= 2'd0;
            s_ready <= 1'b0;
        end else begin
            occ     <= occ_nxt;
            s_ready <= (occ_nxt < 2'd2);
        end
    end

    // Head/tail storage: a push into an empty (or draining single) buffer
    // lands in head; a second word waits in tail and moves up on pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (push && (occ == 2'd0 || (occ == 2'd1 && pop)))
                head <= mapped;
            else if (pop && occ == 2'd2)
                head <= tail;
            if (push && occ == 2'd1 && !pop)
                tail <= mapped;
        end
    end

    // Mode register; the word accepted on the load edge still sees the old mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         mode_active <= 2'b00;
        else if (mode_load) mode_active <= mode_in;
    end

    // Output transfer counter, free-running wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   xfer_cnt <= '0;
        else if (pop) xfer_cnt <= xfer_cnt + 1'b1;
    end
endmodule

// File: tb/tb_bit_map_pipe.sv
// Directed bench for bit_map_pipe: vector table plus multi-cycle sequences.
module tb_bit_map_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode_in = 2'b00;
    logic        mode_load = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [63:0] s_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [63:0] m_data;
    logic [1:0]  mode_active;
    logic [15:0] xfer_cnt;

    logic [1:0]  mode_in2 = 2'b00;
    logic        mode_load2 = 1'b0;
    logic        s_valid2 = 1'b0;
    logic        s_ready2;
    logic [7:0]  s_data2 = '0;
    logic        m_valid2;
    logic        m_ready2 = 1'b0;
    logic [7:0]  m_data2;
    logic [1:0]  mode_active2;
    logic [3:0]  xfer_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bit_map_pipe #(.LANES(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .mode_in(mode_in), .mode_load(mode_load),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .mode_active(mode_active), .xfer_cnt(xfer_cnt)
    );

    bit_map_pipe #(.LANES(1), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .mode_in(mode_in2), .mode_load(mode_load2),
        .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data2),
        .m_valid(m_valid2), .m_ready(m_ready2), .m_data(m_data2),
        .mode_active(mode_active2), .xfer_cnt(xfer_cnt2)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [63:0] din;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        s_valid = 1'b0; m_ready = 1'b0; mode_load = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    logic [63:0] outq[$];
    bit          acc, popn;

    initial begin
        vecs[0] = '{2'b01, 64'h0102_0408_1020_4080, 64'h8008_4004_2002_1001};
        vecs[1] = '{2'b10, 64'h8008_4004_2002_1001, 64'h0102_0408_1020_4080};
        vecs[2] = '{2'b11, 64'h0303_0303_0303_0303, 64'hC0C0_C0C0_C0C0_C0C0};
        vecs[3] = '{2'b00, 64'hA5A5_A5A5_A5A5_A5A5, 64'hA5A5_A5A5_A5A5_A5A5};
        vecs[4] = '{2'b11, 64'h0102_0408_1020_4080, 64'h8040_2010_0804_0201};
        vecs[5] = '{2'b01, 64'hFF00_FF00_0F0F_F0F0, 64'hFF00_FF00_CCCC_3333};
        vecs[6] = '{2'b10, 64'h0F0F_F0F0_0000_FFFF, 64'hAAAA_5555_0000_FFFF};

        // Reset state, asserted and held.
        #3;
        chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
        chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
        chk("rst_mode", {62'd0, mode_active}, 64'd0);
        chk("rst_xfer_cnt", {48'd0, xfer_cnt}, 64'd0);
        chk("rst_m_data", m_data, 64'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("s_ready_before_edge", {63'd0, s_ready}, 64'd0);
        step();
        chk("s_ready_after_edge", {63'd0, s_ready}, 64'd1);

        // Table: load mode, push one word, check it one cycle later.
        foreach (vecs[i]) begin
            mode_in = vecs[i].mode; mode_load = 1'b1;
            step();
            mode_load = 1'b0;
            s_valid = 1'b1; s_data = vecs[i].din; m_ready = 1'b1;
            step();
            s_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), {63'd0, m_valid}, 64'd1);
            chk($sformatf("vec%0d_data", i), m_data, vecs[i].exp);
            step();
            chk($sformatf("vec%0d_drained", i), {63'd0, m_valid}, 64'd0);
        end
        chk("table_xfer_cnt", {48'd0, xfer_cnt}, 64'd7);

        // Backpressure: three words offered with m_ready low.
        do_reset();
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 64'h1111;
        step();
        s_data = 64'h2222;
        step();
        s_data = 64'h3333;
        chk("bp_full_ready", {63'd0, s_ready}, 64'd0);
        step();
        chk("bp_still_full", {63'd0, s_ready}, 64'd0);
        chk("bp_head_hold", m_data, 64'h1111);
        m_ready = 1'b1;
        outq.delete();
        for (int cyc = 0; cyc < 10; cyc++) begin
            popn = m_valid & m_ready;
            acc  = s_valid & s_ready;
            if (popn) outq.push_back(m_data);
            step();
            if (acc) s_valid = 1'b0;
            if (outq.size() == 3 && !s_valid) break;
        end
        chk("bp_count", outq.size(), 3);
        chk("bp_w1", (outq.size() > 0) ? outq[0] : 64'hX, 64'h1111);
        chk("bp_w2", (outq.size() > 1) ? outq[1] : 64'hX, 64'h2222);
        chk("bp_w3", (outq.size() > 2) ? outq[2] : 64'hX, 64'h3333);
        chk("bp_xfer_cnt", {48'd0, xfer_cnt}, 64'd3);
        chk("bp_empty", {63'd0, m_valid}, 64'd0);

        // Mode switch on the same edge as word A.
        do_reset();
        m_ready = 1'b1;
        s_valid = 1'b1; s_data = 64'h0102_0408_1020_4080;
        mode_in = 2'b01; mode_load = 1'b1;
        step();
        mode_load = 1'b0;
        chk("ms_a_bypass", m_data, 64'h0102_0408_1020_4080);
        chk("ms_mode", {62'd0, mode_active}, 64'd1);
        step();
        s_valid = 1'b0;
        chk("ms_b_reverse", m_data, 64'h8008_4004_2002_1001);
        step();

        // Reset with two words held.
        m_ready = 1'b0;
        s_valid = 1'b1; s_data = 64'hAAAA;
        step();
        s_data = 64'hBBBB;
        step();
        s_valid = 1'b0;
        chk("rr_full", {63'd0, s_ready}, 64'd0);
        rst_n = 1'b0;
        #1;
        chk("rr_m_valid", {63'd0, m_valid}, 64'd0);
        chk("rr_xfer_cnt", {48'd0, xfer_cnt}, 64'd0);
        chk("rr_s_ready", {63'd0, s_ready}, 64'd0);
        step();
        rst_n = 1'b1;
        m_ready = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            step();
            chk($sformatf("rr_no_stale%0d", cyc), {63'd0, m_valid}, 64'd0);
        end
        chk("rr_cnt_after", {48'd0, xfer_cnt}, 64'd0);

        // LANES=1, CNT_W=4: 17 back-to-back transfers of 0x80 in mode 01.
        mode_in2 = 2'b01; mode_load2 = 1'b1;
        step();
        mode_load2 = 1'b0;
        s_valid2 = 1'b1; s_data2 = 8'h80; m_ready2 = 1'b1;
        for (int e = 0; e < 18; e++) begin
            step();
            if (e == 0) chk("l1_data", {56'd0, m_data2}, 64'h01);
        end
        s_valid2 = 1'b0;
        chk("l1_wrap_cnt", {60'd0, xfer_cnt2}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
